// File: rtl/sumador_serial_8bits.sv
// sumador_serial_8bits
//   Bit-serial adder: out = in1 + in2 mod 2^WIDTH, one bit per clock, LSB
//   first, using a single full-adder cell and a carry flip-flop. Used beside
//   the combinational subtractor so that sumador(restador(a,b), b) == a.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE
//   in1    first operand (difference), captured when start is accepted
//   in2    second operand (subtrahend), captured when start is accepted
//   out    sum, low WIDTH bits (held until the next done)
//   cout   carry out of the MSB (unsigned overflow)
//   ovf    signed overflow
//   busy   high in RUN and DONE
//   done   one-cycle pulse, out/cout/ovf newly valid
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one sum bit per edge, WIDTH edges
// S_DONE | results valid, done pulse, back to idle next edge

module sumador_serial_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    count;
  logic             carry;
  logic             a_msb, b_msb;

  logic load, step, last;
  logic sum_bit, carry_nxt;
  logic [WIDTH-1:0] r_nxt;

  assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign r_nxt     = {sum_bit, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (count == LAST_BIT) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      count <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      out   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_sr  <= in1;
      b_sr  <= in2;
      r_sr  <= '0;
      carry <= 1'b0;
      count <= '0;
      a_msb <= in1[WIDTH-1];
      b_msb <= in2[WIDTH-1];
    end else if (step) begin
      r_sr  <= r_nxt;
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      carry <= carry_nxt;
      count <= count + 1'b1;
      if (last) begin
        // On the last edge sum_bit is the result MSB, so overflow is known now.
        out  <= r_nxt;
        cout <= carry_nxt;
        ovf  <= (a_msb == b_msb) && (sum_bit != a_msb);
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_sumador_serial_8bits.sv
module tb_sumador_serial_8bits;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] in1, in2;
  logic [W-1:0] out;
  logic         cout, ovf, busy, done;

  int checks = 0;
  int errors = 0;

  // scoreboard entries: {ovf, cout, out}
  logic [W+1:0] exp_q[$];

  sumador_serial_8bits #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .in1  (in1),
    .in2  (in2),
    .out  (out),
    .cout (cout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b};
    v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {v, s[W], s[W-1:0]};
  endfunction

  function automatic logic [W-1:0] restador(input logic [W-1:0] a, input logic [W-1:0] b);
    return a - b;
  endfunction

  // Drives one start pulse; returns at the negedge right after acceptance.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done at a negedge; n = negedges waited, -1 on timeout.
  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (done) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out, cout, ovf, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got out=%h cout=%b ovf=%b busy=%b done=%b, required all zero",
               out, cout, ovf, busy, done);
    end
  endtask

  task automatic test_basic;
    int n;
    logic [W+1:0] e;
    start_op(8'h25, 8'h1B);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b, required 1", busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL basic_hold_during_run: got %h, required 00", out);
    end
    wait_done(20, n);
    checks++;
    if (n != W - 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d, required %0d", n, W - 3);
    end
    e = exp_q.pop_front();
    checks++;
    if ({ovf, cout, out} !== e || out !== 8'h40) begin
      errors++;
      $display("FAIL basic_result: got out=%h cout=%b ovf=%b, required out=40 cout=%b ovf=%b",
               out, cout, ovf, e[W], e[W+1]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out, cout, ovf, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: got out=%h cout=%b ovf=%b busy=%b done=%b, required all zero",
               out, cout, ovf, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_carry_ovf;
    logic [W-1:0] ta[3];
    logic [W-1:0] tb_[3];
    logic [W+1:0] want[3];
    int n;
    logic [W+1:0] e;
    ta[0] = 8'hFF; tb_[0] = 8'h01; want[0] = {1'b0, 1'b1, 8'h00};
    ta[1] = 8'h7F; tb_[1] = 8'h01; want[1] = {1'b1, 1'b0, 8'h80};
    ta[2] = 8'h80; tb_[2] = 8'h80; want[2] = {1'b1, 1'b1, 8'h00};
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb_[i]);
      wait_done(20, n);
      checks++;
      if (n != W) begin
        errors++;
        $display("FAIL carry_latency[%0d]: got %0d, required %0d", i, n, W);
      end
      e = exp_q.pop_front();
      checks++;
      if ({ovf, cout, out} !== e || e !== want[i]) begin
        errors++;
        $display("FAIL carry_result[%0d]: got out=%h cout=%b ovf=%b, required out=%h cout=%b ovf=%b",
                 i, out, cout, ovf, want[i][W-1:0], want[i][W], want[i][W+1]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int n;
    int extra;
    logic [W+1:0] e;
    start_op(8'h10, 8'h20);
    repeat (2) @(negedge clk);
    in1   = 8'hAA;
    in2   = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, n);
    checks++;
    if (n != W - 3) begin
      errors++;
      $display("FAIL ignored_latency: got %0d, required %0d", n, W - 3);
    end
    e = exp_q.pop_front();
    checks++;
    if ({ovf, cout, out} !== e || out !== 8'h30) begin
      errors++;
      $display("FAIL ignored_result: got out=%h, required 30", out);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignored_no_second_op: got %0d busy/done cycles, required 0", extra);
    end
    checks++;
    if (out !== 8'h30) begin
      errors++;
      $display("FAIL ignored_hold: got out=%h, required 30", out);
    end
  endtask

  task automatic test_reset_midop;
    int n;
    int seen;
    logic [W+1:0] e;
    start_op(8'h0F, 8'h01);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_clear: got out=%h busy=%b, required 00 0", out, busy);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0 || out !== 8'h00) begin
      errors++;
      $display("FAIL midop_no_done: got %0d done pulses out=%h, required 0 and 00", seen, out);
    end
    start_op(8'h03, 8'h04);
    wait_done(20, n);
    checks++;
    if (n != W) begin
      errors++;
      $display("FAIL midop_latency: got %0d, required %0d", n, W);
    end
    e = exp_q.pop_front();
    checks++;
    if ({ovf, cout, out} !== e || out !== 8'h07) begin
      errors++;
      $display("FAIL midop_result: got out=%h, required 07", out);
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 1000;
    logic [W-1:0] a_arr[N];
    logic [W-1:0] b_arr[N];
    int n;
    logic [W+1:0] e;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = W'($urandom_range(0, 255));
      b_arr[i] = W'($urandom_range(0, 255));
    end
    @(negedge clk);
    in1   = restador(a_arr[0], b_arr[0]);
    in2   = b_arr[0];
    start = 1'b1;
    exp_q.push_back(model(in1, in2));
    for (int i = 0; i < N; i++) begin
      wait_done(30, n);
      if (n < 0) begin
        checks++;
        errors++;
        $display("FAIL b2b_timeout[%0d]: got no done, required done", i);
        break;
      end
      if (i > 0) begin
        checks++;
        if (n != W + 2) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d, required %0d", i, n, W + 2);
        end
      end
      e = exp_q.pop_front();
      checks++;
      if (out !== a_arr[i]) begin
        errors++;
        $display("FAIL b2b_roundtrip[%0d]: got out=%h, required %h", i, out, a_arr[i]);
      end
      checks++;
      if ({ovf, cout} !== e[W+1:W]) begin
        errors++;
        $display("FAIL b2b_flags[%0d]: got cout=%b ovf=%b, required cout=%b ovf=%b",
                 i, cout, ovf, e[W], e[W+1]);
      end
      if (i < N - 1) begin
        in1 = restador(a_arr[i+1], b_arr[i+1]);
        in2 = b_arr[i+1];
        exp_q.push_back(model(in1, in2));
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_async_reset();
    test_carry_ovf();
    test_ignored_start();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
